// File: rtl/coef_mul_issue_pkg.sv
// Shared parameters and FSM encoding for the coefficient multiply/issue stage.
package coef_mul_issue_pkg;

  localparam int CMI_N = 256;   // coefficients per block
  localparam int CMI_Q = 3329;  // modulus for operand range check
  localparam int CMI_W = 12;    // operand width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/coef_mul_issue_mul_w_x_w.sv
// Registered W x W unsigned multiplier; acts as pipeline stage 2.
module mul_w_x_w
  import coef_mul_issue_pkg::*;
#(
  parameter int W = CMI_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  output logic [2*W-1:0] p
);

  // Capture the full-width product whenever the pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      p         <= (2*W)'(a) * (2*W)'(b);
    end
  end

endmodule

// File: rtl/coef_mul_issue.sv
// Block-based coefficient multiplier: accepts N operand pairs per start,
// issues N full-width products to the downstream reducer.
module coef_mul_issue
  import coef_mul_issue_pkg::*;
#(
  parameter int N = CMI_N,
  parameter int Q = CMI_Q,
  parameter int W = CMI_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_a,
  input  logic [W-1:0]   s_b,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [2*W-1:0] m_c,
  output logic           m_last,
  output logic           busy,
  output logic           done,
  output logic           err_range
);

  localparam int             CW     = $clog2(N) + 1;
  localparam logic [CW-1:0]  N_CNT  = CW'(N);
  localparam logic [CW-1:0]  N_LAST = CW'(N - 1);
  localparam logic [W:0]     Q_LIM  = (W+1)'(Q);

  issue_state_t  state, state_nxt;
  logic [CW-1:0] in_cnt, out_cnt;
  logic          s1_valid;
  logic [W-1:0]  s1_a, s1_b;
  logic          advance, accept, xfer, start_blk, out_of_range;

  // Stage 2 empty or draining this cycle: the whole pipe may shift.
  assign advance      = !m_valid || m_ready;
  assign accept       = s_valid && s_ready;
  assign xfer         = m_valid && m_ready;
  assign start_blk    = start && (state == ST_IDLE);
  assign out_of_range = ({1'b0, s_a} >= Q_LIM) || ({1'b0, s_b} >= Q_LIM);
  assign m_last       = m_valid && (out_cnt == N_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-derived outputs.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy    = 1'b1;
        s_ready = (in_cnt < N_CNT) && advance;
        if (in_cnt == N_CNT) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (xfer && m_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Block counters and sticky range flag; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      err_range <= 1'b0;
    end else if (start_blk) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      err_range <= 1'b0;
    end else begin
      if (accept)                 in_cnt    <= in_cnt + CW'(1);
      if (xfer)                   out_cnt   <= out_cnt + CW'(1);
      if (accept && out_of_range) err_range <= 1'b1;
    end
  end

  // Stage 1 operand register, frozen while stage 2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_a     <= s_a;
      s1_b     <= s_b;
    end
  end

  mul_w_x_w #(.W(W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (advance),
    .in_valid  (s1_valid),
    .a         (s1_a),
    .b         (s1_b),
    .out_valid (m_valid),
    .p         (m_c)
  );

endmodule

// File: tb/tb_coef_mul_issue.sv
// Directed bench for coef_mul_issue.
module tb_coef_mul_issue;

  localparam int N = 256;
  localparam int Q = 3329;
  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst_n, start, s_valid, m_ready;
  logic [W-1:0]  s_a, s_b;
  logic          s_ready, m_valid, m_last, busy, done, err_range;
  logic [2*W-1:0] m_c;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pa [N];
  int unsigned pb [N];

  always #5 clk = ~clk;

  coef_mul_issue #(.N(N), .Q(Q), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_c       (m_c),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .err_range (err_range)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference q=3329 Barrett reducer for 24-bit products.
  function automatic int unsigned barrett(input int unsigned c);
    longint unsigned cl, t, r;
    cl = c;
    t  = (cl * 64'd5039) >> 24;
    r  = cl - t * 64'd3329;
    while (r >= 64'd3329) r = r - 64'd3329;
    return int'(r);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_c"}, m_c, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err_range, 0);
  endtask

  // mode 0: plain stream, latency checked; 1: stall + start in RUN;
  // 2: range/reducer vectors; 3: stop after 100 products (for reset).
  task automatic run_block(input int mode);
    int unsigned in_i, out_i, cyc, done_cnt, target;
    int unsigned acc_cyc [N];
    int unsigned exp_c;
    logic [31:0] held_c;
    target = (mode == 3) ? 100 : N;
    in_i = 0; out_i = 0; cyc = 0; done_cnt = 0; held_c = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_clear_on_start", err_range, 0);
    while (out_i < target && cyc < 3000) begin
      if (done) done_cnt++;
      s_valid = (in_i < N);
      s_a     = W'(in_i < N ? pa[in_i] : 0);
      s_b     = W'(in_i < N ? pb[in_i] : 0);
      m_ready = !(mode == 1 && cyc >= 60 && cyc < 65);
      start   = (mode == 1 && cyc == 30);
      #1;
      if (mode == 1 && cyc >= 60 && cyc < 65) begin
        if (cyc == 60) held_c = 32'(m_c);
        check("stall_m_c_stable", m_c, held_c);
        check("stall_m_valid", m_valid, 1);
        check("stall_s_ready_low", s_ready, 0);
      end
      if (s_valid && s_ready) begin
        acc_cyc[in_i] = cyc;
        if (mode == 2 && in_i == 100) check("err_before_bad", err_range, 0);
        in_i++;
      end
      if (m_valid && m_ready) begin
        exp_c = pa[out_i] * pb[out_i];
        check("product", m_c, exp_c);
        check("m_last", m_last, (out_i == N - 1) ? 1 : 0);
        if (mode == 0) check("latency", cyc - acc_cyc[out_i], 2);
        if (mode == 2 && out_i == 0)   check("max_inrange", m_c, 11075584);
        if (mode == 2 && out_i == 101) check("max_operand", m_c, 16769025);
        if (mode == 2 && pa[out_i] < Q && pb[out_i] < Q)
          check("reduced", barrett(32'(m_c)), (pa[out_i] * pb[out_i]) % Q);
        out_i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    check("block_count", out_i, target);
    check("no_early_done", done_cnt, 0);
    if (mode != 3) begin
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 0);
      check("m_valid_drained", m_valid, 0);
      check("err_after_block", err_range, (mode == 2) ? 1 : 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
      check("err_sticky_idle", err_range, (mode == 2) ? 1 : 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    s_a = '0; s_b = '0;
    #1;
    check_all_zero("reset");
    #20 rst_n = 1'b1;

    for (int i = 0; i < N; i++) begin
      pa[i] = i;
      pb[i] = i + 1;
    end
    run_block(0);
    run_block(1);

    for (int i = 0; i < N; i++) begin
      pa[i] = $urandom_range(0, Q - 1);
      pb[i] = $urandom_range(0, Q - 1);
    end
    pa[0] = 3328; pb[0] = 3328;
    pa[100] = 3329; pb[100] = 1;
    pa[101] = 4095; pb[101] = 4095;
    run_block(2);

    for (int i = 0; i < N; i++) begin
      pa[i] = (i * 13) % Q;
      pb[i] = 3328 - i;
    end
    run_block(0);

    run_block(3);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("no_done_after_reset", done, 0);
      check("idle_after_reset", busy, 0);
    end
    run_block(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coef_mul_issue.md
COEF_MUL_ISSUE -- requirements
Module: coef_mul_issue

Interface
REQ-001 SHALL have parameter N, 256: coefficients per block transfer.
REQ-002 SHALL have parameter Q, 3329: modulus that operands are range-checked against.
REQ-003 SHALL have parameter W, 12: operand width; product width is 2*W.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a block of N products.
REQ-007 SHALL have port s_valid, input, 1: operand pair valid.
REQ-008 SHALL have port s_ready, output, 1: operand pair accepted when s_valid && s_ready.
REQ-009 SHALL have port s_a and s_b, inputs, W each: coefficient operands.
REQ-010 SHALL have port m_valid, output, 1: product valid toward the downstream reducer.
REQ-011 SHALL have port m_ready, input, 1: downstream accepts when m_valid && m_ready.
REQ-012 SHALL have port m_c, output, 2*W: unsigned product s_a*s_b, which is the reducer's C input.
REQ-013 SHALL have port m_last, output, 1: marks the Nth product of the block.
REQ-014 SHALL have port busy, output, 1: high in RUN or DRAIN.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the last product transfers.
REQ-016 SHALL have port err_range, output, 1: sticky flag set when an accepted operand is >= Q.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on start, RUN -> DRAIN when accepted count reaches N, DRAIN -> DONE when the m_last transfer occurs, and DONE -> IDLE unconditionally after one cycle.
REQ-018 SHALL ignore start outside IDLE; SHALL clear counters and err_range on start in IDLE.
REQ-019 SHALL use a 2-stage pipeline (operand register, then product register); with m_ready held high, an accepted pair appears on m_c exactly 2 cycles later.
REQ-020 SHALL stall the whole pipeline when stage-2 is valid and m_ready is low; m_c/m_valid/m_last stay stable until transfer.
REQ-021 SHALL drive s_ready = (state==RUN) && (in_cnt<N) && pipeline-advance, with no combinational path from s_valid to s_ready.
REQ-022 SHALL keep in_cnt and out_cnt of width clog2(N)+1; neither wraps within a block.
REQ-023 SHALL assert m_last with m_valid only when out_cnt==N-1.
REQ-024 SHALL compute m_c as the full unsigned 2*W-bit product with no truncation (4095*4095 = 16769025).
REQ-025 SHALL pass out-of-range operands unchanged and set err_range, which holds until the next start or reset.
REQ-026 SHALL give simultaneous input acceptance and output transfer in the same cycle full throughput of 1 product/cycle.
REQ-027 SHALL hold done low except for the single DONE cycle; busy SHALL be low in IDLE and DONE.

Reset
REQ-028 SHALL force on rst_n low, asynchronously, state=IDLE, counters=0, pipeline valids=0, m_c=0, and s_ready, m_valid, m_last, busy, done, err_range all 0.
REQ-029 SHALL discard in-flight products on reset mid-block with no done pulse, and require a new start afterwards.

Structure
REQ-030 SHALL take Q, W, N and the FSM state encoding from the shared parameter file that is already included by the reduction units.
REQ-031 SHALL place the multiply in one sub-module, mul_w_x_w, a registered W x W unsigned multiplier that forms pipeline stage 2.

Verification
REQ-032 Bench SHALL cover: start, N pairs a=i, b=i+1, with m_ready=1 -> N products i*(i+1) in order, each 2 cycles after acceptance, m_last on product 255, and done one cycle after that transfer.
REQ-033 Bench SHALL cover: m_ready low for 5 cycles mid-stream -> m_c stable, s_ready low, no loss or duplication, and an order-preserving count of 256.
REQ-034 Bench SHALL cover: a=3328, b=3328 -> m_c=11075584 and err_range=0; a=3329 -> err_range=1 until the next start.
REQ-035 Bench SHALL cover: start pulsed during RUN -> ignored, and the counters continue.
REQ-036 Bench SHALL cover: rst_n low after 100 products -> all outputs 0 immediately; a fresh start then yields 256 products and one done.
REQ-037 Bench SHALL cover: products piped into the team's q=3329 reducer -> the reduced output equals (a*b) mod 3329 for random in-range operands.
